// File: rtl/umul8_inv_div.sv
// Restoring radix-2 divider recovering x = z / y, r = z % y; MUL_DIV_APPROX_LSB_EN skips the L low quotient bits.
// Latency: 8 RUN cycles after the accept edge (8-L when approximate); divide-by-zero and overflow take 1 cycle.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module umul8_inv_div #(
    parameter int unsigned L = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] z,
    input  logic [7:0]  y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  x,
    output logic [7:0]  r,
    output logic        dz,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef MUL_DIV_APPROX_LSB_EN
    localparam logic [2:0] LAST_BIT = 3'(L);
`else
    // L only matters in approximate builds.
    localparam logic [2:0] LAST_BIT = 3'(0 * L);
`endif

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  zlo_q, zlo_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  r_q, r_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [8:0]  t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            zlo_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            zlo_q   <= zlo_d;
            y_q     <= y_d;
            x_q     <= x_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        zlo_d   = zlo_q;
        y_d     = y_q;
        x_d     = x_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        t       = {rem_q, zlo_q[cnt_q]};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    zlo_d   = z[7:0];
                    y_d     = y;
                    state_d = RUN;
                    if (y == 8'd0) begin
                        // Error results are decided now; RUN then spends one cycle before DONE.
                        err_d = 1'b1;
                        dz_d  = 1'b1;
                        ovf_d = 1'b0;
                        x_d   = 8'hFF;
                        r_d   = z[7:0];
                    end else if (z[15:8] >= y) begin
                        err_d = 1'b1;
                        dz_d  = 1'b0;
                        ovf_d = 1'b1;
                        x_d   = 8'hFF;
                        r_d   = 8'h00;
                    end else begin
                        err_d = 1'b0;
                        dz_d  = 1'b0;
                        ovf_d = 1'b0;
                        x_d   = 8'h00;
                        r_d   = 8'h00;
                        rem_d = z[15:8];
                        cnt_d = 3'd7;
                    end
                end
            end
            RUN: begin
                if (err_q) begin
                    state_d = DONE;
                end else begin
                    // rem < y holds, so the 8-bit difference is exact.
                    if (t >= {1'b0, y_q}) begin
                        rem_d       = t[7:0] - y_q;
                        x_d[cnt_q]  = 1'b1;
                    end else begin
                        rem_d       = t[7:0];
                        x_d[cnt_q]  = 1'b0;
                    end
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == LAST_BIT) begin
                        r_d     = rem_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x         = x_q;
    assign r         = r_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule
